// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared flappy-bird screen geometry, bird box and game state
package game_pkg;
  localparam int SCREEN_W = 1280;
  localparam int SCREEN_H = 720;
  localparam int BIRD_X   = 180;
  localparam int BIRD_W   = 34;
  localparam int BIRD_H   = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_t;
endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - 8-bit Fibonacci LFSR (taps 8,6,5,4), free-running outside reset
module lfsr8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic feedback;

  assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

  always_ff @(posedge clk) begin
    if (!rst_n) q <= seed;
    else        q <= {q[6:0], feedback};
  end

endmodule

// File: rtl/pipe_field.sv
// rtl/pipe_field.sv - two scrolling pipe pairs, scoring and collision detection
module pipe_field #(
  parameter int SCREEN_W     = 1280,
  parameter int SCREEN_H     = 720,
  parameter int PIPE_W       = 80,
  parameter int GAP_H        = 150,
  parameter int PIPE_SPACING = 640,
  parameter int STEP_DIV     = 500000,
  parameter int SPEED        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        is_start,
  input  logic [11:0] bpos_x,
  input  logic [11:0] bpos_y,
  output logic [11:0] pipe0_x,
  output logic [11:0] pipe0_gap_y,
  output logic [11:0] pipe1_x,
  output logic [11:0] pipe1_gap_y,
  output logic [3:0]  score,
  output logic        hit
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [11:0] GAP_RST = 12'd300;
  localparam logic [11:0] GAP_MIN = 12'd60;

  game_pkg::game_state_t state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [7:0]            lfsr_q;
  logic                  run_en, chk_en, tick, collide, floor_hit;
  logic [1:0]            overlap, passed;
  logic [11:0]           pipe_x   [2];
  logic [11:0]           pipe_gap [2];
  logic [12:0]           bx, by;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (8'hA5),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= game_pkg::IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      game_pkg::IDLE: if (is_start) state_next = game_pkg::RUN;
      game_pkg::RUN:  if (collide)  state_next = game_pkg::OVER;
      default:        state_next = state;
    endcase
  end

  // Collision is watched for the whole RUN state, pause included; the field only moves when enabled.
  always_comb begin
    chk_en = (state == game_pkg::RUN);
    run_en = chk_en && is_start;
  end

  assign bx        = {1'b0, bpos_x};
  assign by        = {1'b0, bpos_y};
  assign floor_hit = (by + 13'(game_pkg::BIRD_H)) >= 13'(SCREEN_H);
  assign collide   = chk_en && ((|overlap) || floor_hit);
  assign tick      = run_en && (cnt == CNT_W'(STEP_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (run_en && !collide) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_pipe
    localparam logic [11:0] X_RST = 12'(SCREEN_W + i * PIPE_SPACING);

    logic [11:0] x_q, gap_q, x_new, gap_new;
    logic [12:0] x13, gap13, right_old, right_new;

    always_comb begin
      x13       = {1'b0, x_q};
      gap13     = {1'b0, gap_q};
      right_old = x13 + 13'(PIPE_W);
      if (x_q < 12'(SPEED)) begin
        x_new   = 12'(SCREEN_W);
        gap_new = GAP_MIN + {3'b000, lfsr_q, 1'b0};
      end else begin
        x_new   = x_q - 12'(SPEED);
        gap_new = gap_q;
      end
      right_new = {1'b0, x_new} + 13'(PIPE_W);
    end

    assign passed[i]  = (right_old >= bx) && (right_new < bx);
    assign overlap[i] = ((bx + 13'(game_pkg::BIRD_W)) > x13) && (bx < right_old) &&
                        ((by < gap13) ||
                         ((by + 13'(game_pkg::BIRD_H)) > (gap13 + 13'(GAP_H))));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        x_q   <= X_RST;
        gap_q <= GAP_RST;
      end else if (tick && !collide) begin
        x_q   <= x_new;
        gap_q <= gap_new;
      end
    end

    assign pipe_x[i]   = x_q;
    assign pipe_gap[i] = gap_q;
  end

  // Pipes are at least half a screen apart, so one increment covers any tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score <= 4'd0;
    end else if (tick && !collide && (|passed) && (score != 4'd15)) begin
      score <= score + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       hit <= 1'b0;
    else if (collide) hit <= 1'b1;
  end

  assign pipe0_x     = pipe_x[0];
  assign pipe0_gap_y = pipe_gap[0];
  assign pipe1_x     = pipe_x[1];
  assign pipe1_gap_y = pipe_gap[1];

endmodule

// File: tb/tb_pipe_field.sv
// tb/tb_pipe_field.sv - randomized self-checking bench for pipe_field against a game-rule model
module tb_pipe_field;

  localparam int STEP_DIV = 4;
  localparam int SPEED    = 2;
  localparam int SCR_W    = 1280;
  localparam int SCR_H    = 720;
  localparam int PIPE_W   = 80;
  localparam int GAP_H    = 150;
  localparam int SPACING  = 640;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        is_start = 1'b0;
  logic [11:0] bpos_x = 12'd180;
  logic [11:0] bpos_y = 12'd360;
  logic [11:0] pipe0_x, pipe0_gap_y, pipe1_x, pipe1_gap_y;
  logic [3:0]  score;
  logic        hit;

  int checks = 0;
  int failures = 0;

  // Game-level reference: phase 0 = waiting, 1 = playing, 2 = game over.
  int m_phase, m_cnt, m_lfsr, m_score, m_hit;
  int m_x[2];
  int m_gap[2];
  bit respawned[2];

  pipe_field #(
    .SCREEN_W(SCR_W), .SCREEN_H(SCR_H), .PIPE_W(PIPE_W), .GAP_H(GAP_H),
    .PIPE_SPACING(SPACING), .STEP_DIV(STEP_DIV), .SPEED(SPEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .is_start(is_start), .bpos_x(bpos_x), .bpos_y(bpos_y),
    .pipe0_x(pipe0_x), .pipe0_gap_y(pipe0_gap_y), .pipe1_x(pipe1_x),
    .pipe1_gap_y(pipe1_gap_y), .score(score), .hit(hit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic check_all();
    check("pipe0_x", int'(pipe0_x), m_x[0]);
    check("pipe0_gap_y", int'(pipe0_gap_y), m_gap[0]);
    check("pipe1_x", int'(pipe1_x), m_x[1]);
    check("pipe1_gap_y", int'(pipe1_gap_y), m_gap[1]);
    check("score", int'(score), m_score);
    check("hit", int'(hit), m_hit);
  endtask

  function automatic bit bird_collides(input int bx, input int by);
    bit c = (by + 24 >= SCR_H);
    for (int i = 0; i < 2; i++)
      if (bx + 34 > m_x[i] && bx < m_x[i] + PIPE_W &&
          (by < m_gap[i] || by + 24 > m_gap[i] + GAP_H)) c = 1;
    return c;
  endfunction

  // One clock: advance the model by the game rules using the inputs held across the edge.
  task automatic step();
    int old_l, o;
    bit scored;
    respawned = '{0, 0};
    @(posedge clk);
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_lfsr = 'hA5; m_score = 0; m_hit = 0;
      m_x[0] = SCR_W; m_x[1] = SCR_W + SPACING; m_gap[0] = 300; m_gap[1] = 300;
    end else begin
      old_l  = m_lfsr;
      m_lfsr = ((m_lfsr << 1) & 'hFF) | (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1);
      if (m_phase == 0) begin
        if (is_start) m_phase = 1;
      end else if (m_phase == 1) begin
        if (bird_collides(int'(bpos_x), int'(bpos_y))) begin
          m_hit = 1; m_phase = 2;
        end else if (is_start) begin
          if (m_cnt == STEP_DIV - 1) begin
            m_cnt = 0; scored = 0;
            for (int i = 0; i < 2; i++) begin
              o = m_x[i];
              if (o < SPEED) begin
                m_x[i] = SCR_W; m_gap[i] = 60 + 2 * old_l; respawned[i] = 1;
              end else m_x[i] = o - SPEED;
              if (o + PIPE_W >= int'(bpos_x) && m_x[i] + PIPE_W < int'(bpos_x)) scored = 1;
            end
            if (scored && m_score < 15) m_score++;
          end else m_cnt++;
        end
      end
    end
    #1;
    check_all();
    if (respawned[0]) begin
      check("respawn0_x", int'(pipe0_x), SCR_W);
      check("respawn0_gap_range", int'(pipe0_gap_y >= 12'd60 && pipe0_gap_y <= 12'd570), 1);
    end
  endtask

  // Keep the bird inside the gap of whichever pipe is nearest to it.
  task automatic track_gap();
    int near = (m_x[0] <= m_x[1]) ? 0 : 1;
    bpos_y = 12'(m_gap[near] + 60);
  endtask

  initial begin
    int guard;
    int pause_left = 0;

    // Reset and idle hold
    rst_n = 1'b0; is_start = 1'b0; bpos_x = 12'd180; bpos_y = 12'd360;
    repeat (3) step();
    check("reset_pipe0_x", int'(pipe0_x), 1280);
    check("reset_pipe1_x", int'(pipe1_x), 1920);
    check("reset_gap0", int'(pipe0_gap_y), 300);
    check("reset_score", int'(score), 0);
    rst_n = 1'b1;
    repeat (100) begin
      bpos_x = 12'($urandom_range(0, 1500)); bpos_y = 12'($urandom_range(0, 900));
      step();
    end
    check("idle_pipe0_x", int'(pipe0_x), 1280);

    // Start: first ticks
    bpos_x = 12'd180; bpos_y = 12'd360; is_start = 1'b1;
    repeat (5) step();
    check("first_tick_x", int'(pipe0_x), 1278);
    repeat (4) step();
    check("second_tick_x", int'(pipe0_x), 1276);
    check("first_ticks_hit", int'(hit), 0);

    // Long run with random pauses, bird tracking gaps; score must saturate
    repeat (25000) begin
      if (pause_left == 0 && $urandom_range(0, 199) == 0) pause_left = $urandom_range(1, 20);
      is_start = (pause_left == 0);
      if (pause_left > 0) pause_left--;
      track_gap();
      step();
    end
    check("score_saturated", int'(score), 15);
    check("long_run_hit", int'(hit), 0);

    // Pipe collision at pipe0_x = 150 with bird above the gap
    rst_n = 1'b0; step(); rst_n = 1'b1; is_start = 1'b1; bpos_y = 12'd360;
    guard = 0;
    while (m_x[0] != 150 && guard < 5000) begin
      track_gap(); step(); guard++;
    end
    check("reach_x150_in_budget", int'(guard < 5000), 1);
    bpos_y = 12'd100;
    step();
    check("pipe_hit", int'(hit), 1);
    check("pipe_hit_x", int'(pipe0_x), 150);
    repeat (40) begin
      is_start = 1'($urandom_range(0, 1));
      bpos_y = 12'($urandom_range(0, 700));
      step();
    end
    check("over_frozen_x", int'(pipe0_x), 150);
    check("over_hit_sticky", int'(hit), 1);
    rst_n = 1'b0; step();
    check("reset_clears_hit", int'(hit), 0);
    check("reset_after_over_x", int'(pipe0_x), 1280);

    // Floor boundary
    rst_n = 1'b1; is_start = 1'b1; bpos_y = 12'd360;
    repeat (3) step();
    bpos_y = 12'd695; step();
    check("floor_695_no_hit", int'(hit), 0);
    bpos_y = 12'd696; step();
    check("floor_696_hit", int'(hit), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
